// File: rtl/glb_port_arbiter.sv
// Burst-atomic round-robin arbiter sharing one GLB SRAM port between host (H) and controller (C).
// Optional beat/wait performance counters are compiled in with `define GLB_ARB_PERF_EN.
module glb_port_arbiter #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 h_req_valid,
  output logic                 h_req_ready,
  input  logic                 h_req_we,
  input  logic                 h_req_last,
  input  logic [ADDR_BITS-1:0] h_req_addr,
  input  logic [DATA_BITS-1:0] h_req_wdata,
  output logic                 h_rsp_valid,
  output logic [DATA_BITS-1:0] h_rsp_data,
  input  logic                 c_req_valid,
  output logic                 c_req_ready,
  input  logic                 c_req_we,
  input  logic                 c_req_last,
  input  logic [ADDR_BITS-1:0] c_req_addr,
  input  logic [DATA_BITS-1:0] c_req_wdata,
  output logic                 c_rsp_valid,
  output logic [DATA_BITS-1:0] c_rsp_data,
  output logic                 glb_we,
  output logic [ADDR_BITS-1:0] glb_w_addr,
  output logic [DATA_BITS-1:0] glb_w_data,
  output logic                 glb_re,
  output logic [ADDR_BITS-1:0] glb_r_addr,
  input  logic [DATA_BITS-1:0] glb_r_data,
`ifdef GLB_ARB_PERF_EN
  output logic [31:0]          h_beat_cnt,
  output logic [31:0]          c_beat_cnt,
  output logic [31:0]          wait_cnt,
`endif
  output logic                 busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_H = 2'd1;
  localparam logic [1:0] OWN_C = 2'd2;

  localparam logic ID_H = 1'b0;
  localparam logic ID_C = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              in_burst_q, in_burst_d;
  logic              last_owner_q, last_owner_d;
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0] tag_id_q, tag_id_d;

  logic own_h, own_c;
  logic h_fire, c_fire, fire;
  logic owner_we, owner_last, owner_valid, other_valid;
  logic exit_vld, exit_id;

  always_comb begin
    own_h       = (state_q == OWN_H);
    own_c       = (state_q == OWN_C);
    h_req_ready = own_h;
    c_req_ready = own_c;
    h_fire      = h_req_valid & own_h;
    c_fire      = c_req_valid & own_c;
    fire        = h_fire | c_fire;
    owner_we    = own_c ? c_req_we   : h_req_we;
    owner_last  = own_c ? c_req_last : h_req_last;
    owner_valid = (own_h & h_req_valid) | (own_c & c_req_valid);
    other_valid = own_h ? c_req_valid : h_req_valid;
    glb_we      = fire & owner_we;
    glb_re      = fire & ~owner_we;
    // Address/data follow the owner; IDLE drives zeros so the port is quiet.
    glb_w_addr  = '0;
    glb_r_addr  = '0;
    glb_w_data  = '0;
    if (own_h) begin
      glb_w_addr = h_req_addr;
      glb_r_addr = h_req_addr;
      glb_w_data = h_req_wdata;
    end else if (own_c) begin
      glb_w_addr = c_req_addr;
      glb_r_addr = c_req_addr;
      glb_w_data = c_req_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    in_burst_d   = in_burst_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (h_req_valid && c_req_valid) begin
          state_d = (last_owner_q == ID_H) ? OWN_C : OWN_H;
        end else if (h_req_valid) begin
          state_d = OWN_H;
        end else if (c_req_valid) begin
          state_d = OWN_C;
        end
      end
      OWN_H, OWN_C: begin
        // An unfinished burst locks the port to its owner, even across valid gaps.
        if (fire) begin
          if (owner_last) begin
            in_burst_d   = 1'b0;
            last_owner_d = own_c ? ID_C : ID_H;
            if (other_valid) begin
              state_d = own_h ? OWN_C : OWN_H;
            end
          end else begin
            in_burst_d = 1'b1;
          end
        end else if (!in_burst_q && other_valid) begin
          state_d = own_h ? OWN_C : OWN_H;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = glb_re;
    tag_id_d[0]  = own_c;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
    exit_vld    = tag_vld_q[RD_LAT-1];
    exit_id     = tag_id_q[RD_LAT-1];
    h_rsp_valid = exit_vld & (exit_id == ID_H);
    c_rsp_valid = exit_vld & (exit_id == ID_C);
    h_rsp_data  = h_rsp_valid ? glb_r_data : '0;
    c_rsp_data  = c_rsp_valid ? glb_r_data : '0;
    busy        = ((state_q != IDLE) & (in_burst_q | owner_valid)) | (|tag_vld_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      in_burst_q   <= 1'b0;
      last_owner_q <= ID_H;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      in_burst_q   <= in_burst_d;
      last_owner_q <= last_owner_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
    end
  end

`ifdef GLB_ARB_PERF_EN
  logic [31:0] h_beat_cnt_q, c_beat_cnt_q, wait_cnt_q;
  logic        blocked;

  assign blocked    = (h_req_valid & ~h_req_ready) | (c_req_valid & ~c_req_ready);
  assign h_beat_cnt = h_beat_cnt_q;
  assign c_beat_cnt = c_beat_cnt_q;
  assign wait_cnt   = wait_cnt_q;

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_beat_cnt_q <= '0;
      c_beat_cnt_q <= '0;
      wait_cnt_q   <= '0;
    end else begin
      if (h_fire && (h_beat_cnt_q != 32'hFFFF_FFFF)) h_beat_cnt_q <= h_beat_cnt_q + 32'd1;
      if (c_fire && (c_beat_cnt_q != 32'hFFFF_FFFF)) c_beat_cnt_q <= c_beat_cnt_q + 32'd1;
      if (blocked && (wait_cnt_q != 32'hFFFF_FFFF))  wait_cnt_q   <= wait_cnt_q + 32'd1;
    end
  end
`endif

endmodule
